// File: rtl/video_vram_arbiter.sv
// video_vram_arbiter
//   Time-shares one single-port 16-bit x 8K video RAM between the display
//   fetch path and the CPU byte bus. Display normally wins. A CPU request
//   that has been denied MAX_WAIT consecutive cycles steals the slot, and the
//   display receives that slot's RAM word with oDispValid=0 ("snow").
//
//   Slot timeline: arbitration at edge E registers the RAM command, the RAM
//   samples it at E+1, and read data is captured at E+2.
//
//   Ports
//     iClk, iRstN                   clock, asynchronous active-low reset
//     iDispReq/iDispAddr            display word fetch request
//     oDispData/oDispValid          fetched word, 2 cycles after the request
//     iCpuReq/iCpuWr/iCpuAddr/iCpuWrData   CPU byte request (level, held to ack)
//     oCpuRdData/oCpuAck            read byte / one-cycle completion pulse
//     oRamAddr/oRamWe/oRamBe/oRamWrData    RAM command (registered)
//     iRamRdData                    RAM read data, 1-cycle latency
//
//   Optional build macro VRAM_WR_POST_EN: CPU writes are accepted into a
//   one-entry post buffer and acked at E+1; the buffer then drains to RAM
//   under the normal priority and wait rules.
module video_vram_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iDispReq,
    input  logic [12:0] iDispAddr,
    output logic [15:0] oDispData,
    output logic        oDispValid,
    input  logic        iCpuReq,
    input  logic        iCpuWr,
    input  logic [13:0] iCpuAddr,
    input  logic [7:0]  iCpuWrData,
    output logic [7:0]  oCpuRdData,
    output logic        oCpuAck,
    output logic [12:0] oRamAddr,
    output logic        oRamWe,
    output logic [1:0]  oRamBe,
    output logic [15:0] oRamWrData,
    input  logic [15:0] iRamRdData
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic        s1_disp_q, s1_disp_d, s1_steal_q, s1_steal_d;
    logic        s1_rd_q, s1_rd_d, s1_lsb_q, s1_lsb_d;
    logic        s2_disp_q, s2_steal_q, s2_rd_q, s2_lsb_q;
    logic [15:0] disp_data_q, disp_data_d;
    logic        disp_valid_q;
    logic [7:0]  cpu_rd_q, cpu_rd_d;
    logic        ack_q, ack_d;
    logic [12:0] ram_addr_q, ram_addr_d;
    logic        ram_we_q, ram_we_d;
    logic [1:0]  ram_be_q, ram_be_d;
    logic [15:0] ram_wd_q, ram_wd_d;

    logic        cpu_busy, cpu_src, cpu_pend, op_wr;
    logic [13:0] op_addr;
    logic [7:0]  op_data;
    logic        steal, cpu_grant, disp_win;

`ifdef VRAM_WR_POST_EN
    logic        buf_q, buf_d;
    logic [13:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        accept_wr;
`endif

    always_comb begin
`ifdef VRAM_WR_POST_EN
        // The buffered write is the CPU-side contender; a read is only
        // considered once the buffer is empty so it cannot overtake it.
        cpu_busy  = s1_rd_q | s2_rd_q | ack_q;
        accept_wr = iCpuReq & iCpuWr & ~cpu_busy & ~buf_q;
        cpu_src   = buf_q | iCpuReq;
        cpu_pend  = buf_q | (iCpuReq & ~iCpuWr & ~cpu_busy & ~buf_q);
        op_wr     = buf_q;
        op_addr   = buf_q ? buf_addr_q : iCpuAddr;
        op_data   = buf_data_q;
`else
        // ram_we_q marks a write granted last edge (its ack is due now);
        // ack_q blocks the cycle after the ack so a held request is ignored.
        cpu_busy  = s1_rd_q | ram_we_q | s2_rd_q | ack_q;
        cpu_src   = iCpuReq;
        cpu_pend  = iCpuReq & ~cpu_busy;
        op_wr     = iCpuWr;
        op_addr   = iCpuAddr;
        op_data   = iCpuWrData;
`endif
        steal     = cpu_pend & (wait_q == WAIT_MAX);
        cpu_grant = steal | (cpu_pend & ~iDispReq);
        disp_win  = iDispReq & ~steal;

        if (!cpu_src || cpu_grant)
            wait_d = '0;
        else if (cpu_pend && wait_q != WAIT_MAX)
            wait_d = wait_q + 1'b1;
        else
            wait_d = wait_q;

        s1_disp_d  = disp_win;
        s1_steal_d = iDispReq & cpu_grant;
        s1_rd_d    = cpu_grant & ~op_wr;
        s1_lsb_d   = op_addr[0];

        ram_addr_d = ram_addr_q;
        ram_wd_d   = ram_wd_q;
        ram_we_d   = cpu_grant & op_wr;
        ram_be_d   = '0;
        if (disp_win)
            ram_addr_d = iDispAddr;
        else if (cpu_grant)
            ram_addr_d = op_addr[13:1];
        if (cpu_grant && op_wr) begin
            ram_be_d = op_addr[0] ? 2'b01 : 2'b10;
            ram_wd_d = {op_data, op_data};
        end

        disp_data_d = (s2_disp_q | s2_steal_q) ? iRamRdData : disp_data_q;
        cpu_rd_d    = cpu_rd_q;
        if (s2_rd_q)
            cpu_rd_d = s2_lsb_q ? iRamRdData[7:0] : iRamRdData[15:8];

`ifdef VRAM_WR_POST_EN
        ack_d      = accept_wr | s2_rd_q;
        buf_d      = buf_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (buf_q && cpu_grant)
            buf_d = 1'b0;
        if (accept_wr) begin
            buf_d      = 1'b1;
            buf_addr_d = iCpuAddr;
            buf_data_d = iCpuWrData;
        end
`else
        ack_d = ram_we_q | s2_rd_q;
`endif
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wait_q       <= '0;
            s1_disp_q    <= 1'b0;
            s1_steal_q   <= 1'b0;
            s1_rd_q      <= 1'b0;
            s1_lsb_q     <= 1'b0;
            s2_disp_q    <= 1'b0;
            s2_steal_q   <= 1'b0;
            s2_rd_q      <= 1'b0;
            s2_lsb_q     <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            cpu_rd_q     <= '0;
            ack_q        <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_be_q     <= '0;
            ram_wd_q     <= '0;
`ifdef VRAM_WR_POST_EN
            buf_q        <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
`endif
        end else begin
            wait_q       <= wait_d;
            s1_disp_q    <= s1_disp_d;
            s1_steal_q   <= s1_steal_d;
            s1_rd_q      <= s1_rd_d;
            s1_lsb_q     <= s1_lsb_d;
            s2_disp_q    <= s1_disp_q;
            s2_steal_q   <= s1_steal_q;
            s2_rd_q      <= s1_rd_q;
            s2_lsb_q     <= s1_lsb_q;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= s2_disp_q;
            cpu_rd_q     <= cpu_rd_d;
            ack_q        <= ack_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_be_q     <= ram_be_d;
            ram_wd_q     <= ram_wd_d;
`ifdef VRAM_WR_POST_EN
            buf_q        <= buf_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
`endif
        end
    end

    assign oDispData  = disp_data_q;
    assign oDispValid = disp_valid_q;
    assign oCpuRdData = cpu_rd_q;
    assign oCpuAck    = ack_q;
    assign oRamAddr   = ram_addr_q;
    assign oRamWe     = ram_we_q;
    assign oRamBe     = ram_be_q;
    assign oRamWrData = ram_wd_q;

endmodule

// File: tb/tb_video_vram_arbiter.sv
// tb_video_vram_arbiter
//   Scoreboard bench for video_vram_arbiter. The driver issues directed and
//   random traffic; a reference model (shadow memory plus per-slot priority
//   rules) pushes expected display words, CPU acks and RAM write commands into
//   queues tagged with the edge they are due; a monitor on the falling edge
//   pops and compares. A behavioural synchronous RAM closes the loop.
//   Honours VRAM_WR_POST_EN the same way as the design.
module tb_video_vram_arbiter;

    localparam int unsigned MAXW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iDispReq = 1'b0;
    logic [12:0] iDispAddr = '0;
    logic [15:0] oDispData;
    logic        oDispValid;
    logic        iCpuReq = 1'b0;
    logic        iCpuWr = 1'b0;
    logic [13:0] iCpuAddr = '0;
    logic [7:0]  iCpuWrData = '0;
    logic [7:0]  oCpuRdData;
    logic        oCpuAck;
    logic [12:0] oRamAddr;
    logic        oRamWe;
    logic [1:0]  oRamBe;
    logic [15:0] oRamWrData;
    logic [15:0] ram_rd;

    video_vram_arbiter #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
        .iClk(clk), .iRstN(rst_n),
        .iDispReq(iDispReq), .iDispAddr(iDispAddr),
        .oDispData(oDispData), .oDispValid(oDispValid),
        .iCpuReq(iCpuReq), .iCpuWr(iCpuWr), .iCpuAddr(iCpuAddr),
        .iCpuWrData(iCpuWrData), .oCpuRdData(oCpuRdData), .oCpuAck(oCpuAck),
        .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamBe(oRamBe),
        .oRamWrData(oRamWrData), .iRamRdData(ram_rd)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [15:0] init_word(int i);
        return 16'((i * 40503) ^ (i >> 3) ^ 16'h1F2E);
    endfunction

    // Behavioural RAM: read-before-write, 1-cycle read latency.
    logic [15:0] mem [8192];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_word(i);
            ram_init <= 1'b1;
        end else begin
            ram_rd <= mem[oRamAddr];
            if (oRamWe && oRamBe[1]) mem[oRamAddr][15:8] <= oRamWrData[15:8];
            if (oRamWe && oRamBe[0]) mem[oRamAddr][7:0]  <= oRamWrData[7:0];
        end
    end

    typedef struct { int due; bit valid; logic [15:0] data; } disp_t;
    typedef struct { int due; bit rd; logic [7:0] data; } cpu_t;
    typedef struct { int due; logic [12:0] addr; logic [1:0] be; logic [15:0] data; } ram_t;
    disp_t disp_q[$];
    cpu_t  cpu_q[$];
    ram_t  ram_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic miss(string name, int due);
        checks++;
        errors++;
        $display("FAIL %s: got nothing expected event at edge %0d (now %0d)", name, due, edge_n);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] shadow [8192];
    int  waitc = 0, next_ok = 0, ack_edge = 0;
    bit  cpu_on = 1'b0, granted = 1'b0, want_cpu = 1'b0;
    bit  w_wr;
    logic [13:0] w_addr;
    logic [7:0]  w_data;
`ifdef VRAM_WR_POST_EN
    bit  buf_full = 1'b0;
    logic [13:0] buf_addr;
    logic [7:0]  buf_data;
`endif

    task automatic push_disp(int due, bit v, logic [15:0] d);
        disp_t x; x.due = due; x.valid = v; x.data = d; disp_q.push_back(x);
    endtask
    task automatic push_cpu(int due, bit rd, logic [7:0] d);
        cpu_t x; x.due = due; x.rd = rd; x.data = d; cpu_q.push_back(x);
    endtask
    task automatic push_ram(int due, logic [12:0] a, logic [1:0] be, logic [15:0] d);
        ram_t x; x.due = due; x.addr = a; x.be = be; x.data = d; ram_q.push_back(x);
    endtask

    // Decide the slot at edge e from the inputs about to be sampled there.
    task automatic model(int e);
        bit pend, steal, grant, opwr, src;
        logic [13:0] oa;
        logic [7:0]  od;
        logic [12:0] wa;
        logic [15:0] word;
`ifdef VRAM_WR_POST_EN
        bit acc;
        acc  = cpu_on && !granted && iCpuWr && e >= next_ok && !buf_full;
        src  = buf_full || iCpuReq;
        pend = buf_full || (cpu_on && !granted && !iCpuWr && e >= next_ok);
        opwr = buf_full;
        oa   = buf_full ? buf_addr : iCpuAddr;
        od   = buf_data;
`else
        src  = iCpuReq;
        pend = cpu_on && !granted && e >= next_ok;
        opwr = iCpuWr;
        oa   = iCpuAddr;
        od   = iCpuWrData;
`endif
        steal = pend && waitc == int'(MAXW);
        grant = steal || (pend && !iDispReq);
        if (iDispReq && !steal) push_disp(e + 2, 1'b1, shadow[iDispAddr]);
        if (grant) begin
            wa = oa[13:1];
            word = shadow[wa];
            if (iDispReq) push_disp(e + 2, 1'b0, word);
            if (opwr) begin
                push_ram(e, wa, oa[0] ? 2'b01 : 2'b10, {od, od});
                if (oa[0]) shadow[wa][7:0] = od;
                else       shadow[wa][15:8] = od;
`ifdef VRAM_WR_POST_EN
                buf_full = 1'b0;
`else
                push_cpu(e + 1, 1'b0, 8'h00);
                ack_edge = e + 1; next_ok = e + 3; granted = 1'b1;
`endif
            end else begin
                push_cpu(e + 2, 1'b1, oa[0] ? word[7:0] : word[15:8]);
                ack_edge = e + 2; next_ok = e + 4; granted = 1'b1;
            end
        end
`ifdef VRAM_WR_POST_EN
        if (acc) begin
            buf_full = 1'b1; buf_addr = iCpuAddr; buf_data = iCpuWrData;
            push_cpu(e + 1, 1'b0, 8'h00);
            ack_edge = e + 1; next_ok = e + 3; granted = 1'b1;
        end
`endif
        if (!src || grant) waitc = 0;
        else if (pend && waitc < int'(MAXW)) waitc++;
    endtask

    // ---------------- driver ----------------
    task automatic step(bit dreq, logic [12:0] daddr);
        int e;
        e = edge_n + 1;
        if (cpu_on && granted && e > ack_edge) begin
            cpu_on = 1'b0;
            iCpuReq = 1'b0;
        end
        if (want_cpu && !cpu_on) begin
            cpu_on = 1'b1; granted = 1'b0;
            iCpuReq = 1'b1; iCpuWr = w_wr; iCpuAddr = w_addr; iCpuWrData = w_data;
        end
        want_cpu = 1'b0;
        iDispReq = dreq;
        iDispAddr = daddr;
        model(e);
        @(posedge clk); #1;
    endtask

    task automatic issue(bit wr, logic [13:0] a, logic [7:0] d);
        want_cpu = 1'b1; w_wr = wr; w_addr = a; w_data = d;
    endtask

    task automatic wait_cpu_idle(string name);
        for (int i = 0; i < 60 && cpu_on; i++) step(1'b0, '0);
        if (cpu_on) miss(name, edge_n);
        repeat (3) step(1'b0, '0);
    endtask

    task automatic do_reset(string name);
        rst_n = 1'b0;
        disp_q.delete(); cpu_q.delete(); ram_q.delete();
        cpu_on = 1'b0; granted = 1'b0; want_cpu = 1'b0;
        iCpuReq = 1'b0; iDispReq = 1'b0;
        waitc = 0; next_ok = 0;
`ifdef VRAM_WR_POST_EN
        buf_full = 1'b0;
`endif
        #1;
        chk(name, 64'({oDispValid, oDispData, oCpuAck, oCpuRdData, oRamAddr,
                       oRamWe, oRamBe, oRamWrData}), 64'd0);
        @(posedge clk); #1;
        chk(name, 64'({oDispValid, oDispData, oCpuAck, oCpuRdData, oRamAddr,
                       oRamWe, oRamBe, oRamWrData}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        int k;
        disp_t d;
        cpu_t c;
        ram_t r;
        if (rst_n) begin
            k = edge_n;
            while (disp_q.size() > 0 && disp_q[0].due < k) begin
                miss("disp_missing", disp_q[0].due);
                void'(disp_q.pop_front());
            end
            if (disp_q.size() > 0 && disp_q[0].due == k) begin
                d = disp_q.pop_front();
                chk("disp_valid", 64'(oDispValid), 64'(d.valid));
                chk("disp_data", 64'(oDispData), 64'(d.data));
            end else if (oDispValid) begin
                chk("disp_unexpected", 64'(oDispValid), 64'd0);
            end

            while (cpu_q.size() > 0 && cpu_q[0].due < k) begin
                miss("cpu_ack_missing", cpu_q[0].due);
                void'(cpu_q.pop_front());
            end
            if (oCpuAck) begin
                if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 64'(oCpuAck), 64'd0);
                else begin
                    c = cpu_q.pop_front();
                    chk("cpu_ack_edge", 64'(k), 64'(c.due));
                    if (c.rd) chk("cpu_rd_data", 64'(oCpuRdData), 64'(c.data));
                end
            end

            while (ram_q.size() > 0 && ram_q[0].due < k) begin
                miss("ram_wr_missing", ram_q[0].due);
                void'(ram_q.pop_front());
            end
            if (oRamWe) begin
                if (ram_q.size() == 0) chk("ram_wr_unexpected", 64'(oRamWe), 64'd0);
                else begin
                    r = ram_q.pop_front();
                    chk("ram_wr_edge", 64'(k), 64'(r.due));
                    chk("ram_addr", 64'(oRamAddr), 64'(r.addr));
                    chk("ram_be", 64'(oRamBe), 64'(r.be));
                    chk("ram_wdata", 64'(oRamWrData), 64'(r.data));
                end
            end else begin
                chk("ram_be_idle", 64'(oRamBe), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 8192; i++) shadow[i] = init_word(i);
        do_reset("reset_state");
        repeat (2) step(1'b0, '0);

        // Idle-bus write then read back of byte address 0x0003.
        issue(1'b1, 14'h0003, 8'hA5);
        wait_cpu_idle("wr_timeout");
        issue(1'b0, 14'h0003, 8'h00);
        wait_cpu_idle("rd_timeout");

        // Back-to-back display fetches of words 0..15.
        for (int n = 0; n < 16; n++) step(1'b1, 13'(n));
        repeat (4) step(1'b0, '0);

        // Continuous display with a pending CPU read: bounded-wait steal.
        issue(1'b0, 14'h0011, 8'h00);
        for (int n = 0; n < 20; n++) step(1'b1, 13'(n + 4));
        wait_cpu_idle("steal_timeout");

        // CPU request in a display-free cycle is granted immediately.
        issue(1'b1, 14'h0020, 8'h3C);
        step(1'b0, '0);
        for (int n = 0; n < 6; n++) step(1'b1, 13'(n));
        wait_cpu_idle("free_slot_timeout");

        // Reset one cycle after a read grant drops the pending ack.
        issue(1'b0, 14'h0006, 8'h00);
        step(1'b0, '0);
        step(1'b0, '0);
        do_reset("reset_mid_op");
        repeat (4) step(1'b0, '0);
        issue(1'b0, 14'h0006, 8'h00);
        wait_cpu_idle("post_reset_timeout");

        // Randomised traffic, alternating moderate and saturated display load.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0)
                issue(1'($urandom_range(0, 1)), 14'($urandom_range(0, 63)), 8'($urandom));
            step(($urandom_range(0, 9) < (((i / 250) % 2 == 1) ? 10 : 6)),
                 13'($urandom_range(0, 31)));
        end
        wait_cpu_idle("final_timeout");
        repeat (4) step(1'b0, '0);
        chk("queues_drained", 64'(disp_q.size() + cpu_q.size() + ram_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
